// File: rtl/digit_serial_addsub_if.sv
// Operand/result handshake bundle for the digit-serial adder/subtractor.
// The master side supplies operands and accepts results; the slave side is
// the arithmetic block.
interface digit_serial_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );
endinterface

// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: one DIGIT-wide adder is reused NDIG times,
// LSB digit first, with a registered carry between digits. Subtraction is
// done as a + ~b + ~borrow_in, so c_out=1 means "no borrow" in that mode.
module digit_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  digit_serial_addsub_if.slave    bus
);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("digit_serial_addsub: DIGIT must be in 1..WIDTH and divide WIDTH");
  end

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // already inverted when subtracting
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             in_ready;
  logic             out_valid;
  int               base;
  logic [DIGIT-1:0] a_dig, b_dig, sum_dig;
  logic             sum_carry;

  // Shared digit adder: current digit of a and b' plus the carry register.
  always_comb begin
    base  = int'(cnt_q) * DIGIT;
    a_dig = a_q[base +: DIGIT];
    b_dig = b_q[base +: DIGIT];
    {sum_carry, sum_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    carry_d   = carry_q;
    c_out_d   = c_out_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.c_in ^ bus.sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        s_d[base +: DIGIT] = sum_dig;
        carry_d            = sum_carry;
        if (cnt_q == LAST) begin
          // The MSB digit is being summed now, so its top bit is the result sign.
          c_out_d = sum_carry;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_dig[DIGIT-1] != a_q[WIDTH-1]);
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over everything and clears all.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.s         = s_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: three instances (DIGIT = 4, 1, 16) driven
// through directed scenarios and random operations, compared with an
// integer-arithmetic reference model.
module tb_digit_serial_addsub;
  localparam int WIDTH = 16;
  localparam int NDUT  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst         [NDUT];
  logic             in_valid    [NDUT];
  logic             out_ready   [NDUT];
  logic             c_in_i      [NDUT];
  logic             sub_i       [NDUT];
  logic [WIDTH-1:0] a_i         [NDUT];
  logic [WIDTH-1:0] b_i         [NDUT];
  logic             in_ready_w  [NDUT];
  logic             out_valid_w [NDUT];
  logic             c_out_w     [NDUT];
  logic             ovf_w       [NDUT];
  logic [WIDTH-1:0] s_w         [NDUT];

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_s;
  logic             exp_c;
  logic             exp_v;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    digit_serial_addsub_if #(.WIDTH(WIDTH)) bus ();

    assign bus.in_valid   = in_valid[g];
    assign bus.a          = a_i[g];
    assign bus.b          = b_i[g];
    assign bus.c_in       = c_in_i[g];
    assign bus.sub        = sub_i[g];
    assign bus.out_ready  = out_ready[g];
    assign in_ready_w[g]  = bus.in_ready;
    assign out_valid_w[g] = bus.out_valid;
    assign s_w[g]         = bus.s;
    assign c_out_w[g]     = bus.c_out;
    assign ovf_w[g]       = bus.ovf;

    digit_serial_addsub #(
      .WIDTH(WIDTH),
      .DIGIT(g == 0 ? 4 : (g == 1 ? 1 : 16))
    ) dut (
      .clk(clk),
      .rst(rst[g]),
      .bus(bus)
    );
  end

  function automatic int digit_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 16);
  endfunction

  function automatic string tg(input int k, input string name);
    return $sformatf("%s/digit%0d", name, digit_of(k));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands' unsigned and signed values.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sb);
    int unsigned ur;
    int          sa, sbv, sr;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (!sb) begin
      ur = int'(a) + int'(b) + int'(cin);
      sr = sa + sbv + int'(cin);
    end else begin
      ur = 65536 + int'(a) - int'(b) - int'(cin);
      sr = sa - sbv - int'(cin);
    end
    exp_s = ur[WIDTH-1:0];
    exp_c = (ur >= 65536);
    exp_v = (sr > 32767) || (sr < -32768);
  endtask

  task automatic accept(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sb);
    int w = 0;
    while (!in_ready_w[k] && w < 64) begin
      tick();
      w++;
    end
    check(tg(k, "in_ready_wait"), 32'(in_ready_w[k]), 32'd1);
    model(a, b, cin, sb);
    a_i[k]      = a;
    b_i[k]      = b;
    c_in_i[k]   = cin;
    sub_i[k]    = sb;
    in_valid[k] = 1'b1;
    tick();
    // Operands only matter on the accepting edge; scramble them afterwards.
    in_valid[k] = 1'b0;
    a_i[k]      = 16'($urandom);
    b_i[k]      = 16'($urandom);
    c_in_i[k]   = 1'($urandom);
    sub_i[k]    = 1'($urandom);
  endtask

  task automatic await_result(input int k);
    int cyc = 0;
    while (!out_valid_w[k] && cyc < 64) begin
      check(tg(k, "in_ready_busy"), 32'(in_ready_w[k]), 32'd0);
      tick();
      cyc++;
    end
    check(tg(k, "latency"), 32'(cyc), 32'(WIDTH / digit_of(k)));
    check(tg(k, "out_valid"), 32'(out_valid_w[k]), 32'd1);
    check(tg(k, "in_ready_done"), 32'(in_ready_w[k]), 32'd0);
    check(tg(k, "s"), 32'(s_w[k]), 32'(exp_s));
    check(tg(k, "c_out"), 32'(c_out_w[k]), 32'(exp_c));
    check(tg(k, "ovf"), 32'(ovf_w[k]), 32'(exp_v));
  endtask

  task automatic run_op(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sb);
    out_ready[k] = 1'b1;
    accept(k, a, b, cin, sb);
    await_result(k);
    tick();
    check(tg(k, "out_valid_after"), 32'(out_valid_w[k]), 32'd0);
    check(tg(k, "in_ready_after"), 32'(in_ready_w[k]), 32'd1);
  endtask

  task automatic backpressure(input int k);
    out_ready[k] = 1'b0;
    accept(k, 16'h1234, 16'h4321, 1'b1, 1'b0);
    await_result(k);
    for (int i = 0; i < 3; i++) begin
      in_valid[k] = 1'b1;
      a_i[k]      = 16'($urandom);
      b_i[k]      = 16'($urandom);
      tick();
      check(tg(k, "bp_out_valid"), 32'(out_valid_w[k]), 32'd1);
      check(tg(k, "bp_in_ready"), 32'(in_ready_w[k]), 32'd0);
      check(tg(k, "bp_s"), 32'(s_w[k]), 32'(exp_s));
      check(tg(k, "bp_c_out"), 32'(c_out_w[k]), 32'(exp_c));
      check(tg(k, "bp_ovf"), 32'(ovf_w[k]), 32'(exp_v));
    end
    out_ready[k] = 1'b1;
    tick();
    check(tg(k, "bp_release_out_valid"), 32'(out_valid_w[k]), 32'd0);
    check(tg(k, "bp_release_in_ready"), 32'(in_ready_w[k]), 32'd1);
    run_op(k, 16'h0F0F, 16'h00F1, 1'b0, 1'b1);
  endtask

  task automatic mid_reset(input int k);
    out_ready[k] = 1'b1;
    accept(k, 16'h1234, 16'h4321, 1'b1, 1'b0);
    if (digit_of(k) != WIDTH) begin
      check(tg(k, "mr_run1_out_valid"), 32'(out_valid_w[k]), 32'd0);
      tick();
    end
    check(tg(k, "mr_run2_out_valid"), 32'(out_valid_w[k]), 32'd0);
    rst[k] = 1'b1;
    tick();
    rst[k] = 1'b0;
    check(tg(k, "mr_out_valid"), 32'(out_valid_w[k]), 32'd0);
    check(tg(k, "mr_in_ready"), 32'(in_ready_w[k]), 32'd1);
    check(tg(k, "mr_s"), 32'(s_w[k]), 32'd0);
    check(tg(k, "mr_c_out"), 32'(c_out_w[k]), 32'd0);
    check(tg(k, "mr_ovf"), 32'(ovf_w[k]), 32'd0);
    run_op(k, 16'h00FF, 16'h0001, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      rst[k]       = 1'b1;
      in_valid[k]  = 1'b1;
      out_ready[k] = 1'b0;
      a_i[k]       = 16'hA5A5;
      b_i[k]       = 16'h5A5A;
      c_in_i[k]    = 1'b1;
      sub_i[k]     = 1'b0;
    end
    tick();
    tick();
    for (int k = 0; k < NDUT; k++) begin
      check(tg(k, "rst_in_ready"), 32'(in_ready_w[k]), 32'd1);
      check(tg(k, "rst_out_valid"), 32'(out_valid_w[k]), 32'd0);
      check(tg(k, "rst_s"), 32'(s_w[k]), 32'd0);
      check(tg(k, "rst_c_out"), 32'(c_out_w[k]), 32'd0);
      check(tg(k, "rst_ovf"), 32'(ovf_w[k]), 32'd0);
      in_valid[k] = 1'b0;
      rst[k]      = 1'b0;
    end
    tick();

    for (int k = 0; k < NDUT; k++) begin
      run_op(k, 16'h1234, 16'h4321, 1'b1, 1'b0);
      run_op(k, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      run_op(k, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
      run_op(k, 16'h0005, 16'h0007, 1'b0, 1'b1);
      run_op(k, 16'h8000, 16'h0001, 1'b0, 1'b1);
      run_op(k, 16'h0000, 16'h0000, 1'b1, 1'b1);
      backpressure(k);
      mid_reset(k);
    end

    for (int i = 0; i < 1000; i++) begin
      run_op(i % NDUT, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
